bp_update_ctrl: RTL and testbench

Controller that owns the single table port of `branch_prediction`. It shares that port between fetch-stage lookups and resolved-branch updates, and buffers resolved branches in a small queue. It also detects mispredictions at resolution and generates the one-cycle `flushbp` pulse with the recovery PC. It sits between the fetch stage, the decode/execute branch-resolution logic and the predictor table.

---
 rtl/bp_pkg.sv | 28 ++
 rtl/bp_update_fifo.sv | 51 +++++
 rtl/bp_update_ctrl.sv | 121 ++++++++++++
 tb/tb_bp_update_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-predictor update controller.
// Holds the queued-update record, the flush FSM states and the counter limits.
package bp_pkg;

  localparam logic [1:0] CTR_MAX = 2'b11;
  localparam logic [1:0] CTR_MIN = 2'b00;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  ctr;
  } bp_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } bp_state_e;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] next_ctr(input logic [1:0] ctr, input logic taken);
    logic [1:0] r;
    if (taken) r = (ctr == CTR_MAX) ? CTR_MAX : ctr + 2'd1;
    else       r = (ctr == CTR_MIN) ? CTR_MIN : ctr - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// FIFO of resolved-branch updates waiting for the shared predictor table port.
// Count spans 0..QDEPTH so full and empty never alias.
module bp_update_fifo
  import bp_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  bp_entry_t                 din,
  output bp_entry_t                 dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(QDEPTH):0]   count
);

  localparam int PW = $clog2(QDEPTH);

  bp_entry_t     mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(QDEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// Owns the single predictor-table port: arbitrates fetch lookups against queued
// resolved-branch updates and raises a one-cycle flush on mispredictions.
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int IDX_W  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup_req,
  input  logic [31:0]      lookup_pc,
  output logic             lookup_stall,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [31:0]      res_pc,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic             res_pred_taken,
  input  logic [31:0]      res_pred_target,
  input  logic [1:0]       res_ctr,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [1:0]       tbl_wctr,
  output logic             tbl_wtgt_en,
  output logic [31:0]      tbl_wtgt,
  output logic             flushbp,
  output logic [31:0]      redirect_pc,
  output bp_state_e        state_dbg
);

  bp_state_e                state;
  bp_entry_t                push_entry;
  bp_entry_t                head;
  logic                     q_full;
  logic                     q_empty;
  logic [$clog2(QDEPTH):0]  q_count;
  logic                     push;
  logic                     pop;
  logic                     mispredict;
  logic [31:0]              recover_pc;

  // Resolution handshake: an update is accepted on a cycle where res_valid and
  // res_ready are both 1; res_ready is purely !full and ignores a same-cycle pop.
  assign res_ready = !q_full;
  assign push      = res_valid && res_ready;

  assign push_entry = '{pc: res_pc, taken: res_taken, target: res_target, ctr: res_ctr};

  assign mispredict = (res_taken != res_pred_taken) ||
                      (res_taken && res_pred_taken && (res_target != res_pred_target));
  assign recover_pc = res_taken ? res_target : res_pc + 32'd4;

  bp_update_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      flushbp     <= 1'b0;
      redirect_pc <= '0;
    end else begin
      if (push && mispredict) begin
        state       <= FLUSH;
        flushbp     <= 1'b1;
        redirect_pc <= recover_pc;
      end else begin
        state       <= RUN;
        flushbp     <= 1'b0;
      end
    end
  end

  assign state_dbg = state;

  // Port arbitration: first matching rule wins.
  always_comb begin
    tbl_en       = 1'b0;
    tbl_we       = 1'b0;
    tbl_addr     = '0;
    tbl_wctr     = CTR_MIN;
    tbl_wtgt_en  = 1'b0;
    tbl_wtgt     = '0;
    lookup_stall = 1'b0;
    pop          = 1'b0;
    if (q_empty) begin
      if (lookup_req) begin
        tbl_en   = 1'b1;
        tbl_addr = lookup_pc[IDX_W+1:2];
      end
    end else if (state == FLUSH || !lookup_req || q_full) begin
      pop          = 1'b1;
      tbl_en       = 1'b1;
      tbl_we       = 1'b1;
      tbl_addr     = head.pc[IDX_W+1:2];
      tbl_wctr     = next_ctr(head.ctr, head.taken);
      tbl_wtgt_en  = head.taken;
      tbl_wtgt     = head.target;
      lookup_stall = q_full && (state != FLUSH) && lookup_req;
    end else begin
      tbl_en   = 1'b1;
      tbl_addr = lookup_pc[IDX_W+1:2];
    end
  end

  // Only the index bits of each PC address the table.
  logic unused_bits;
  assign unused_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                         head.pc[31:IDX_W+2], head.pc[1:0], q_count};

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl: reset, correct/mispredicted resolutions,
// queue-full arbitration with FIFO drain, and reset while flushing.
module tb_bp_update_ctrl;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_req;
  logic [31:0] lookup_pc;
  logic        lookup_stall;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic [1:0]  res_ctr;
  logic        tbl_en;
  logic        tbl_we;
  logic [5:0]  tbl_addr;
  logic [1:0]  tbl_wctr;
  logic        tbl_wtgt_en;
  logic [31:0] tbl_wtgt;
  logic        flushbp;
  logic [31:0] redirect_pc;
  bp_state_e   state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bp_update_ctrl #(.QDEPTH(4), .IDX_W(6)) dut (
    .clk             (clk),
    .reset           (reset),
    .lookup_req      (lookup_req),
    .lookup_pc       (lookup_pc),
    .lookup_stall    (lookup_stall),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_pc          (res_pc),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .res_ctr         (res_ctr),
    .tbl_en          (tbl_en),
    .tbl_we          (tbl_we),
    .tbl_addr        (tbl_addr),
    .tbl_wctr        (tbl_wctr),
    .tbl_wtgt_en     (tbl_wtgt_en),
    .tbl_wtgt        (tbl_wtgt),
    .flushbp         (flushbp),
    .redirect_pc     (redirect_pc),
    .state_dbg       (state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic pred,
                         input logic [31:0] tgt, input logic [31:0] ptgt, input logic [1:0] ctr);
    res_valid       = 1'b1;
    res_pc          = pc;
    res_taken       = taken;
    res_pred_taken  = pred;
    res_target      = tgt;
    res_pred_target = ptgt;
    res_ctr         = ctr;
  endtask

  initial begin
    reset = 1'b1; lookup_req = 1'b0; lookup_pc = '0;
    res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
    res_pred_taken = 1'b0; res_pred_target = '0; res_ctr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;

    chk("rst_flushbp", flushbp, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_ready", res_ready, 1);
    chk("rst_stall", lookup_stall, 0);
    chk("rst_tbl_en", tbl_en, 0);
    chk("rst_tbl_we", tbl_we, 0);
    chk("rst_state", state_dbg, RUN);

    // Correct prediction: write lands one cycle after the push.
    @(negedge clk); resolve(32'h4, 1, 1, 32'h90, 32'h90, 2'b10); #1;
    chk("ok_push_idle", tbl_en, 0);
    @(negedge clk); res_valid = 1'b0; #1;
    chk("ok_flushbp", flushbp, 0);
    chk("ok_we", tbl_we, 1);
    chk("ok_addr", tbl_addr, 1);
    chk("ok_wctr", tbl_wctr, 2'b11);
    chk("ok_wtgt_en", tbl_wtgt_en, 1);
    chk("ok_wtgt", tbl_wtgt, 32'h90);
    next_cycle();
    chk("ok_drained", tbl_en, 0);

    // Mispredict, predicted not taken.
    @(negedge clk); resolve(32'h4, 1, 0, 32'h90, 32'h0, 2'b01);
    @(negedge clk); res_valid = 1'b0; #1;
    chk("mnt_flushbp", flushbp, 1);
    chk("mnt_redirect", redirect_pc, 32'h90);
    chk("mnt_state", state_dbg, FLUSH);
    chk("mnt_wctr", tbl_wctr, 2'b10);
    chk("mnt_stall", lookup_stall, 0);
    next_cycle();
    chk("mnt_pulse_end", flushbp, 0);

    // Mispredict, predicted taken.
    @(negedge clk); resolve(32'h4, 0, 1, 32'h90, 32'h90, 2'b00);
    @(negedge clk); res_valid = 1'b0; #1;
    chk("mt_flushbp", flushbp, 1);
    chk("mt_redirect", redirect_pc, 32'h8);
    chk("mt_we", tbl_we, 1);
    chk("mt_wctr", tbl_wctr, 2'b00);
    chk("mt_wtgt_en", tbl_wtgt_en, 0);
    next_cycle();
    chk("mt_pulse_end", flushbp, 0);

    // Queue full under continuous lookups.
    lookup_req = 1'b1; lookup_pc = 32'h3C;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      resolve(32'h10 * (i + 1), 1, 1, 32'h200 + i, 32'h200 + i, 2'b01);
      #1;
      chk("qf_lookup_we", tbl_we, 0);
      chk("qf_lookup_addr", tbl_addr, 15);
    end
    // Full: offered mispredict must be refused.
    @(negedge clk); resolve(32'h50, 0, 1, 32'h0, 32'h0, 2'b10); #1;
    chk("qf_ready", res_ready, 0);
    chk("qf_stall", lookup_stall, 1);
    chk("qf_we", tbl_we, 1);
    chk("qf_addr0", tbl_addr, 4);
    chk("qf_wctr0", tbl_wctr, 2'b10);
    @(negedge clk); res_valid = 1'b0; #1;
    chk("qf_no_flush", flushbp, 0);
    chk("qf_ready_again", res_ready, 1);
    chk("qf_lookup_back", tbl_we, 0);
    chk("qf_stall_off", lookup_stall, 0);
    @(negedge clk); lookup_req = 1'b0; #1;
    chk("qf_addr1", tbl_addr, 8);
    next_cycle();
    chk("qf_addr2", tbl_addr, 12);
    next_cycle();
    chk("qf_addr3", tbl_addr, 16);
    chk("qf_wtgt3", tbl_wtgt, 32'h203);
    next_cycle();
    chk("qf_empty", tbl_en, 0);

    // Reset while flushing with two entries queued.
    lookup_req = 1'b1;
    @(negedge clk); resolve(32'h20, 1, 1, 32'h300, 32'h300, 2'b01);
    @(negedge clk); resolve(32'h24, 1, 0, 32'h400, 32'h0, 2'b01);
    @(negedge clk); res_valid = 1'b0; #1;
    chk("rf_flushbp", flushbp, 1);
    chk("rf_write_pending", tbl_we, 1);
    #2 reset = 1'b1; #1;
    chk("rf_flushbp_clr", flushbp, 0);
    chk("rf_redirect_clr", redirect_pc, 0);
    chk("rf_ready", res_ready, 1);
    chk("rf_we", tbl_we, 0);
    chk("rf_state", state_dbg, RUN);
    @(negedge clk); reset = 1'b0; lookup_req = 1'b0; #1;
    chk("rf_no_write", tbl_en, 0);
    next_cycle();
    chk("rf_still_idle", tbl_en, 0);
    chk("rf_still_noflush", flushbp, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
